w_writeback_grf: RTL and testbench

Write-back stage and general register file for the five-stage MIPS pipeline. Consumes the W-stage bundle from the memory/write-back pipeline register, decodes the destination register and result source, and commits to a 32×32-bit GRF. Serves the D stage's two combinational read ports with internal W→D bypass, and exports the W-stage write tuple to the hazard/forwarding unit.

---
 rtl/cpu_defs_pkg.sv | 67 ++++++
 rtl/w_writeback_grf_wb_decode.sv | 61 ++++++
 rtl/w_writeback_grf.sv | 107 ++++++++++
 tb/tb_w_writeback_grf.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared MIPS pipeline definitions: opcodes, functs, write-back selects.
// Used by the write-back stage, its decoder and the GRF.
package cpu_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC8 = 2'd2
  } wd_sel_e;

  typedef struct packed {
    logic       we;
    logic [4:0] wa;
    wd_sel_e    wd_sel;
  } wb_ctrl_t;

  function automatic logic is_alu_fn(
    input logic [5:0] fn
  );
    return (fn == FN_ADD) || (fn == FN_SUB) ||
           (fn == FN_AND) || (fn == FN_OR)  ||
           (fn == FN_SLT) || (fn == FN_SLTU);
  endfunction

  function automatic logic is_imm_alu(
    input logic [5:0] op
  );
    return (op == OP_ORI)  || (op == OP_ADDI) ||
           (op == OP_ANDI) || (op == OP_LUI);
  endfunction

  function automatic logic is_load(
    input logic [5:0] op
  );
    return (op == OP_LW) || (op == OP_LH) ||
           (op == OP_LB);
  endfunction

endpackage

// File: rtl/w_writeback_grf_wb_decode.sv
// W-stage decoder: instruction -> {we, wa, wd_sel}.
// The $0 drop is applied by the caller, not here.
module wb_decode
  import cpu_defs_pkg::*;
(
  input  logic [31:0] instr,
  output wb_ctrl_t    ctrl
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       is_r;
  logic       unused_fields;

  assign op   = instr[31:26];
  assign fn   = instr[5:0];
  assign rt   = instr[20:16];
  assign rd   = instr[15:11];
  assign is_r = (op == OP_RTYPE);

  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    ctrl.we     = 1'b0;
    ctrl.wa     = REG_ZERO;
    ctrl.wd_sel = WD_ALU;
    unique case (1'b1)
      is_r && is_alu_fn(fn): begin
        ctrl.we     = 1'b1;
        ctrl.wa     = rd;
        ctrl.wd_sel = WD_ALU;
      end
      is_r && (fn == FN_JALR): begin
        ctrl.we     = 1'b1;
        ctrl.wa     = rd;
        ctrl.wd_sel = WD_PC8;
      end
      is_imm_alu(op): begin
        ctrl.we     = 1'b1;
        ctrl.wa     = rt;
        ctrl.wd_sel = WD_ALU;
      end
      is_load(op): begin
        ctrl.we     = 1'b1;
        ctrl.wa     = rt;
        ctrl.wd_sel = WD_MEM;
      end
      op == OP_JAL: begin
        ctrl.we     = 1'b1;
        ctrl.wa     = REG_RA;
        ctrl.wd_sel = WD_PC8;
      end
      default: begin
        ctrl.we     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/w_writeback_grf.sv
// W stage + 32x32 GRF with W->D bypass and retire counter.
// Define WB_TRACE_EN for a simulation-only commit trace.
module w_writeback_grf
  import cpu_defs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] W_instruction,
  input  logic [31:0] W_pc,
  input  logic [31:0] W_ans,
  input  logic [31:0] W_Rdata,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  output logic [31:0] D_rs_data,
  output logic [31:0] D_rt_data,
  output logic        W_we,
  output logic [4:0]  W_wa,
  output logic [31:0] W_wd,
  output logic [31:0] W_retired
);

  wb_ctrl_t    dec;
  logic [31:0] pc8;
  logic [31:0] wd_raw;
  logic [31:0] grf_q [32];
  logic [31:0] grf_d [32];
  logic [31:0] retired_q;
  logic [31:0] retired_d;

  wb_decode u_dec (
    .instr (W_instruction),
    .ctrl  (dec)
  );

  assign pc8 = W_pc + 32'd8;

  always_comb begin
    wd_raw = W_ans;
    unique case (dec.wd_sel)
      WD_ALU:  wd_raw = W_ans;
      WD_MEM:  wd_raw = W_Rdata;
      WD_PC8:  wd_raw = pc8;
      default: wd_raw = W_ans;
    endcase
  end

  assign W_we = dec.we && (dec.wa != REG_ZERO);
  assign W_wa = W_we ? dec.wa : REG_ZERO;
  assign W_wd = W_we ? wd_raw : 32'd0;

  // Bypass keeps D reads coherent with the write landing this edge.
  always_comb begin
    D_rs_data = grf_q[D_rs_addr];
    if (D_rs_addr == REG_ZERO) begin
      D_rs_data = 32'd0;
    end else if (W_we && (D_rs_addr == W_wa)) begin
      D_rs_data = W_wd;
    end
  end

  always_comb begin
    D_rt_data = grf_q[D_rt_addr];
    if (D_rt_addr == REG_ZERO) begin
      D_rt_data = 32'd0;
    end else if (W_we && (D_rt_addr == W_wa)) begin
      D_rt_data = W_wd;
    end
  end

  always_comb begin
    grf_d = grf_q;
    if (W_we) begin
      grf_d[W_wa] = W_wd;
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (W_instruction != 32'd0) begin
      retired_d = retired_q + 32'd1;
    end
  end

  assign W_retired = retired_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        grf_q[i] <= 32'd0;
      end
      retired_q <= 32'd0;
    end else begin
      grf_q     <= grf_d;
      retired_q <= retired_d;
    end
  end

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (rst && W_we) begin
      $display("@%h: $%d <= %h", W_pc, W_wa, W_wd);
    end
  end
`else
`endif

endmodule

// File: tb/tb_w_writeback_grf.sv
// Randomized self-checking bench for w_writeback_grf.
// Reference model: architectural register array plus retire count.
module tb_w_writeback_grf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] W_instruction;
  logic [31:0] W_pc;
  logic [31:0] W_ans;
  logic [31:0] W_Rdata;
  logic [4:0]  D_rs_addr;
  logic [4:0]  D_rt_addr;
  logic [31:0] D_rs_data;
  logic [31:0] D_rt_data;
  logic        W_we;
  logic [4:0]  W_wa;
  logic [31:0] W_wd;
  logic [31:0] W_retired;

  int checks = 0;
  int failures = 0;

  logic [31:0] mreg [32];
  logic [31:0] mret;

  w_writeback_grf dut (
    .clk           (clk),
    .rst           (rst),
    .W_instruction (W_instruction),
    .W_pc          (W_pc),
    .W_ans         (W_ans),
    .W_Rdata       (W_Rdata),
    .D_rs_addr     (D_rs_addr),
    .D_rt_addr     (D_rt_addr),
    .D_rs_data     (D_rs_data),
    .D_rt_data     (D_rt_data),
    .W_we          (W_we),
    .W_wa          (W_wa),
    .W_wd          (W_wd),
    .W_retired     (W_retired)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [5:0] fn
  );
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

  // Architectural meaning of the W instruction.
  function automatic void ref_wb(
    input  logic [31:0] ins,
    output logic        we,
    output logic [4:0]  wa,
    output logic [31:0] wd
  );
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        w;
    logic [4:0]  dst;
    logic [31:0] val;
    op = ins[31:26];
    fn = ins[5:0];
    w = 1'b0;
    dst = 5'd0;
    val = 32'd0;
    case (op)
      6'h00: begin
        if (fn inside {6'h20, 6'h22, 6'h24,
                       6'h25, 6'h2a, 6'h2b}) begin
          w = 1'b1; dst = ins[15:11]; val = W_ans;
        end else if (fn == 6'h09) begin
          w = 1'b1; dst = ins[15:11]; val = W_pc + 32'd8;
        end
      end
      6'h08, 6'h0c, 6'h0d, 6'h0f: begin
        w = 1'b1; dst = ins[20:16]; val = W_ans;
      end
      6'h20, 6'h21, 6'h23: begin
        w = 1'b1; dst = ins[20:16]; val = W_Rdata;
      end
      6'h03: begin
        w = 1'b1; dst = 5'd31; val = W_pc + 32'd8;
      end
      default: w = 1'b0;
    endcase
    we = w && (dst != 5'd0);
    wa = we ? dst : 5'd0;
    wd = we ? val : 32'd0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    ref_wb(W_instruction, we, wa, wd);
    if (a == 5'd0) return 32'd0;
    if (we && (wa == a)) return wd;
    return mreg[a];
  endfunction

  task automatic drive(
    input logic [31:0] ins, input logic [31:0] pc,
    input logic [31:0] ans, input logic [31:0] rd,
    input logic [4:0] rs, input logic [4:0] rt
  );
    W_instruction = ins;
    W_pc = pc;
    W_ans = ans;
    W_Rdata = rd;
    D_rs_addr = rs;
    D_rt_addr = rt;
    #1;
  endtask

  // Commit one edge in the model and realign to the falling edge.
  task automatic tick;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    ref_wb(W_instruction, we, wa, wd);
    @(posedge clk);
    if (rst) begin
      if (we) mreg[wa] = wd;
      if (W_instruction != 32'd0) mret = mret + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic bubble(input logic [4:0] rs, input logic [4:0] rt);
    drive(32'd0, 32'd0, 32'd0, 32'd0, rs, rt);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mret = 32'd0;
    bubble(5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      D_rs_addr = 5'(a);
      D_rt_addr = 5'(31 - a);
      #1;
      checks++;
      if (D_rs_data !== 32'd0 || D_rt_data !== 32'd0) begin
        failures++;
        $display("FAIL reset_read a=%0d rs=%h rt=%h want 0",
                 a, D_rs_data, D_rt_data);
      end
    end
    checks++;
    if (W_retired !== 32'd0) begin
      failures++;
      $display("FAIL reset_retired got=%h want 0", W_retired);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ori_bypass;
    drive(enc_i(6'h0d, 5'd0, 5'd5, 16'h1234), 32'h100,
          32'h1234, 32'h0, 5'd5, 5'd5);
    checks++;
    if (W_we !== 1'b1 || W_wa !== 5'd5 ||
        D_rs_data !== 32'h1234 || D_rt_data !== 32'h1234) begin
      failures++;
      $display("FAIL ori_bypass we=%b wa=%0d rs=%h rt=%h want 1 5 1234 1234",
               W_we, W_wa, D_rs_data, D_rt_data);
    end
    tick();
    bubble(5'd5, 5'd0);
    checks++;
    if (D_rs_data !== 32'h1234 || W_we !== 1'b0) begin
      failures++;
      $display("FAIL ori_grf rs=%h we=%b want 1234 0", D_rs_data, W_we);
    end
  endtask

  task automatic test_lw;
    drive(enc_i(6'h23, 5'd3, 5'd8, 16'h0040), 32'h104,
          32'h40, 32'hDEADBEEF, 5'd0, 5'd0);
    checks++;
    if (W_wd !== 32'hDEADBEEF || W_wa !== 5'd8) begin
      failures++;
      $display("FAIL lw_wd got=%h/%0d want deadbeef/8", W_wd, W_wa);
    end
    tick();
    bubble(5'd0, 5'd8);
    checks++;
    if (D_rt_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL lw_grf got=%h want deadbeef", D_rt_data);
    end
  endtask

  task automatic test_jal_jalr;
    drive({6'h03, 26'h0000c00}, 32'h00003000, 32'h5, 32'h6,
          5'd0, 5'd0);
    checks++;
    if (W_wa !== 5'd31 || W_wd !== 32'h00003008) begin
      failures++;
      $display("FAIL jal_wd got=%0d/%h want 31/00003008", W_wa, W_wd);
    end
    tick();
    bubble(5'd31, 5'd0);
    checks++;
    if (D_rs_data !== 32'h00003008) begin
      failures++;
      $display("FAIL jal_grf got=%h want 00003008", D_rs_data);
    end
    drive(enc_r(5'd4, 5'd0, 5'd0, 6'h09), 32'h3100, 32'h7, 32'h0,
          5'd0, 5'd0);
    checks++;
    if (W_we !== 1'b0 || W_wa !== 5'd0 || W_wd !== 32'd0) begin
      failures++;
      $display("FAIL jalr_zero we=%b wa=%0d wd=%h want 0 0 0",
               W_we, W_wa, W_wd);
    end
    tick();
    drive({6'h03, 26'h0}, 32'hFFFFFFFC, 32'h0, 32'h0, 5'd31, 5'd0);
    checks++;
    if (W_wd !== 32'h00000004 || D_rs_data !== 32'h00000004) begin
      failures++;
      $display("FAIL pc8_wrap wd=%h rs=%h want 00000004",
               W_wd, D_rs_data);
    end
    tick();
  endtask

  task automatic test_zero_dst;
    drive(enc_r(5'd1, 5'd2, 5'd0, 6'h20), 32'h200, 32'd7, 32'd0,
          5'd0, 5'd0);
    checks++;
    if (W_we !== 1'b0 || D_rs_data !== 32'd0 || W_wd !== 32'd0) begin
      failures++;
      $display("FAIL add_zero we=%b rs=%h wd=%h want 0 0 0",
               W_we, D_rs_data, W_wd);
    end
    tick();
    drive(enc_i(6'h2b, 5'd5, 5'd8, 16'h4), 32'h204, 32'h99, 32'h77,
          5'd8, 5'd0);
    checks++;
    if (W_we !== 1'b0 || D_rs_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_nowrite we=%b rs=%h want 0 deadbeef",
               W_we, D_rs_data);
    end
    tick();
  endtask

  function automatic logic [31:0] rand_instr(input logic [4:0] hot);
    logic [4:0] r1;
    logic [4:0] r2;
    logic [4:0] r3;
    logic [5:0] alu_fns [6];
    logic [5:0] imm_ops [4];
    logic [5:0] ld_ops [3];
    logic [5:0] nw_ops [6];
    alu_fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h2b};
    imm_ops = '{6'h08, 6'h0c, 6'h0d, 6'h0f};
    ld_ops  = '{6'h20, 6'h21, 6'h23};
    nw_ops  = '{6'h28, 6'h29, 6'h2b, 6'h04, 6'h05, 6'h02};
    r1 = 5'($urandom);
    r2 = ($urandom_range(0, 1) == 1) ? hot : 5'($urandom);
    r3 = ($urandom_range(0, 1) == 1) ? hot : 5'($urandom);
    case ($urandom_range(0, 8))
      0, 1: return enc_r(r1, r2, r3, alu_fns[$urandom_range(0, 5)]);
      2:    return enc_r(r1, r2, r3, 6'h09);
      3, 4: return enc_i(imm_ops[$urandom_range(0, 3)], r1, r2,
                         16'($urandom));
      5:    return enc_i(ld_ops[$urandom_range(0, 2)], r1, r2,
                         16'($urandom));
      6:    return {6'h03, 26'($urandom)};
      7:    return enc_i(nw_ops[$urandom_range(0, 5)], r1, r2,
                         16'($urandom));
      default: return ($urandom_range(0, 1) == 1) ? 32'd0 :
                      enc_r(r1, r2, r3, 6'h08);
    endcase
  endfunction

  task automatic test_random;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  hot;
    int          bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      hot = 5'($urandom);
      drive(rand_instr(hot), $urandom, $urandom, $urandom,
            ($urandom_range(0, 2) == 0) ? 5'($urandom) : hot,
            ($urandom_range(0, 2) == 0) ? 5'($urandom) : hot);
      ref_wb(W_instruction, we, wa, wd);
      checks++;
      if (W_we !== we || W_wa !== wa || W_wd !== wd ||
          D_rs_data !== ref_read(D_rs_addr) ||
          D_rt_data !== ref_read(D_rt_addr)) begin
        failures++;
        bad++;
        if (bad < 8)
          $display("FAIL rand n=%0d ins=%h we=%b/%b wa=%0d/%0d wd=%h/%h rs=%h/%h rt=%h/%h",
                   n, W_instruction, W_we, we, W_wa, wa, W_wd, wd,
                   D_rs_data, ref_read(D_rs_addr),
                   D_rt_data, ref_read(D_rt_addr));
      end
      tick();
    end
    bubble(5'd0, 5'd0);
    checks++;
    if (W_retired !== mret) begin
      failures++;
      $display("FAIL rand_retired got=%h want %h", W_retired, mret);
    end
  endtask

  task automatic test_retire_wrap;
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    mret = 32'hFFFFFFFF;
    #1;
    checks++;
    if (W_retired !== mret) begin
      failures++;
      $display("FAIL retire_preload got=%h want %h", W_retired, mret);
    end
    drive(enc_i(6'h0d, 5'd0, 5'd9, 16'h1), 32'h300, 32'h55,
          32'h0, 5'd0, 5'd0);
    tick();
    bubble(5'd9, 5'd0);
    checks++;
    if (W_retired !== 32'd0 || mret !== 32'd0) begin
      failures++;
      $display("FAIL retire_wrap got=%h want 0", W_retired);
    end
  endtask

  task automatic test_async_reset;
    drive(enc_i(6'h0d, 5'd0, 5'd12, 16'h0), 32'h400, 32'hCAFE0001,
          32'h0, 5'd0, 5'd0);
    tick();
    bubble(5'd12, 5'd9);
    checks++;
    if (D_rs_data !== 32'hCAFE0001 || D_rt_data !== 32'h55) begin
      failures++;
      $display("FAIL pre_reset rs=%h rt=%h want cafe0001 55",
               D_rs_data, D_rt_data);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mret = 32'd0;
    checks++;
    if (D_rs_data !== 32'd0 || D_rt_data !== 32'd0 ||
        W_retired !== 32'd0) begin
      failures++;
      $display("FAIL async_reset rs=%h rt=%h ret=%h want 0 0 0",
               D_rs_data, D_rt_data, W_retired);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(enc_i(6'h0f, 5'd0, 5'd12, 16'hBEEF), 32'h500, 32'hBEEF0000,
          32'h0, 5'd12, 5'd12);
    tick();
    bubble(5'd12, 5'd9);
    checks++;
    if (D_rs_data !== ref_read(5'd12) || D_rt_data !== 32'd0 ||
        W_retired !== mret) begin
      failures++;
      $display("FAIL post_reset rs=%h rt=%h ret=%h want %h 0 %h",
               D_rs_data, D_rt_data, W_retired, ref_read(5'd12), mret);
    end
  endtask

  initial begin
    rst = 1'b0;
    W_instruction = 32'd0;
    W_pc = 32'd0;
    W_ans = 32'd0;
    W_Rdata = 32'd0;
    D_rs_addr = 5'd0;
    D_rt_addr = 5'd0;
    @(negedge clk);
    test_reset();
    test_ori_bypass();
    test_lw();
    test_jal_jalr();
    test_zero_dst();
    test_random();
    test_retire_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
